writeback_stage: RTL

- Final pipeline stage: holds the MEM/WB pipeline register, formats load data, selects the register write-back source, and drives the register-file write port consumed by the decode stage (reg_wr / rd / reg_data).
- Drives write-back forwarding data and a one-cycle retire pulse.
- Sits between the memory stage and the decode-stage register file.

---
 rtl/writeback_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, load formatting, write-back mux and retire pulse.
// Define WB_INSTRET_EN to add a retired-instruction counter on wb_instret_out.
module writeback_stage #(
  parameter int XLEN     = 32,
  parameter int RETIRE_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid_in,
  input  logic                wb_stall_in,
  input  logic                wb_flush_in,
  input  logic                wb_reg_wr_in,
  input  logic [1:0]          wb_reg_in_sel_in,
  input  logic [2:0]          wb_func3_in,
  input  logic [4:0]          wb_rd_in,
  input  logic [XLEN-1:0]     wb_alu_res_in,
  input  logic [XLEN-1:0]     wb_mem_rdata_in,
  input  logic [XLEN-1:0]     wb_pc_in,
  input  logic [XLEN-1:0]     wb_imm_in,
  output logic                wb_reg_wr_out,
  output logic [4:0]          wb_rd_out,
  output logic [XLEN-1:0]     wb_reg_data_out,
`ifdef WB_INSTRET_EN
  output logic [RETIRE_W-1:0] wb_instret_out,
`endif
  output logic                wb_retire_out
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_IMM  = 2'b11
  } wb_sel_e;

  if (XLEN != 32 || RETIRE_W < 1) begin : g_param_check
    $error("writeback_stage: XLEN must be 32 and RETIRE_W at least 1");
  end

  logic            valid_q;
  logic            done_q;
  logic            reg_wr_q;
  wb_sel_e         sel_q;
  logic [2:0]      func3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_res_q;
  logic [XLEN-1:0] mem_rdata_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;

  // Stall holds the entry and flush is ignored; done remembers it has already written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      reg_wr_q    <= 1'b0;
      sel_q       <= SEL_ALU;
      func3_q     <= '0;
      rd_q        <= '0;
      alu_res_q   <= '0;
      mem_rdata_q <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
    end else if (!wb_stall_in) begin
      // NOTE: non-blocking assignments so every field samples pre-edge values in parallel.
      valid_q     <= wb_valid_in & ~wb_flush_in;
      done_q      <= 1'b0;
      reg_wr_q    <= wb_reg_wr_in;
      sel_q       <= wb_sel_e'(wb_reg_in_sel_in);
      func3_q     <= wb_func3_in;
      rd_q        <= wb_rd_in;
      alu_res_q   <= wb_alu_res_in;
      mem_rdata_q <= wb_mem_rdata_in;
      pc_q        <= wb_pc_in;
      imm_q       <= wb_imm_in;
    end else begin
      done_q      <= done_q | valid_q;
    end
  end

  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] mux_data;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    load_byte = mem_rdata_q[7:0];
    load_half = alu_res_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
    load_data = mem_rdata_q;
    mux_data  = alu_res_q;

    case (alu_res_q[1:0])
      2'd1:    load_byte = mem_rdata_q[15:8];
      2'd2:    load_byte = mem_rdata_q[23:16];
      2'd3:    load_byte = mem_rdata_q[31:24];
      default: load_byte = mem_rdata_q[7:0];
    endcase

    case (func3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = mem_rdata_q;
    endcase

    case (sel_q)
      SEL_LOAD: mux_data = load_data;
      SEL_PC4:  mux_data = pc_q + 32'd4;
      SEL_IMM:  mux_data = imm_q;
      default:  mux_data = alu_res_q;
    endcase
  end

  assign wb_retire_out   = valid_q & ~done_q;
  assign wb_reg_wr_out   = wb_retire_out & reg_wr_q & (rd_q != 5'd0);
  assign wb_rd_out       = rd_q;
  assign wb_reg_data_out = valid_q ? mux_data : '0;

`ifdef WB_INSTRET_EN
  logic [RETIRE_W-1:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (wb_retire_out) begin
      instret_q <= instret_q + RETIRE_W'(1);
    end
  end

  assign wb_instret_out = instret_q;
`endif

endmodule
